// File: rtl/traffic_pkg.sv
// Shared light codes, direction and phase encodings for the intersection scheduler.
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    typedef enum logic [1:0] {NORTH, SOUTH, EAST, WEST} dir_t;
    typedef enum logic [1:0] {ALL_RED, GREEN_PH, YELLOW_PH, EMERG_PH} phase_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin direction pick: first pending direction after last_i, wrapping back
// to last_i itself; with no demand it falls back to last_i+1 (fixed-time recall).
module traffic_rr_pick
    import traffic_pkg::*;
(
    input  logic [3:0] pending_i,
    input  dir_t       last_i,
    output dir_t       next_o
);

    always_comb begin
        next_o = dir_t'(2'(last_i + 2'd1));
        // Scan farthest-first so the nearest pending direction wins.
        for (int k = 4; k >= 1; k--) begin
            if (pending_i[2'(last_i + 2'(k))]) next_o = dir_t'(2'(last_i + 2'(k)));
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler with yellow/all-red clearance and
// emergency preemption; all timing advances on the 1 s tick strobe.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 4,
    parameter int unsigned ALLRED_T = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic [3:0] req_i,
    input  logic       emerg_valid_i,
    input  logic [1:0] emerg_dir_i,
    output logic [2:0] north_dir_o,
    output logic [2:0] south_dir_o,
    output logic [2:0] east_dir_o,
    output logic [2:0] west_dir_o,
    output logic [1:0] active_dir_o,
    output logic [1:0] phase_o,
    output logic       emerg_ack_o
);

    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_T - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);

    phase_t     phase_q, phase_d;
    dir_t       active_q, active_d;
    logic [7:0] count_q, count_d;
    logic [3:0] pending_q, pending_d;
    dir_t       pick;
    logic       emerg_here;

    traffic_rr_pick u_pick (
        .pending_i (pending_q),
        .last_i    (active_q),
        .next_o    (pick)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q   <= ALL_RED;
            active_q  <= WEST;
            count_q   <= 8'd0;
            pending_q <= 4'd0;
        end else begin
            phase_q   <= phase_d;
            active_q  <= active_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign emerg_here = emerg_valid_i && (dir_t'(emerg_dir_i) == active_q);

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        count_d  = count_q;
        if (tick_i) begin
            count_d = count_q + 8'd1;
            unique case (phase_q)
                ALL_RED: if (count_q == ALLRED_LAST) begin
                    count_d = 8'd0;
                    if (emerg_valid_i) begin
                        phase_d  = EMERG_PH;
                        active_d = dir_t'(emerg_dir_i);
                    end else begin
                        phase_d  = GREEN_PH;
                        active_d = pick;
                    end
                end
                GREEN_PH: if (emerg_here) begin
                    phase_d = EMERG_PH;
                    count_d = 8'd0;
                end else if (emerg_valid_i || count_q == GREEN_LAST) begin
                    phase_d = YELLOW_PH;
                    count_d = 8'd0;
                end
                YELLOW_PH: if (count_q == YELLOW_LAST) begin
                    phase_d = ALL_RED;
                    count_d = 8'd0;
                end
                EMERG_PH: if (!emerg_here) begin
                    phase_d = YELLOW_PH;
                    count_d = 8'd0;
                end
                default: ;
            endcase
        end
        // Demand for a direction is consumed when it is granted the right of way.
        pending_d = pending_q | req_i;
        if (phase_d != phase_q && (phase_d == GREEN_PH || phase_d == EMERG_PH))
            pending_d[active_d] = 1'b0;
    end

    always_comb begin
        logic [3:0][2:0] heads;
        heads = {RED, RED, RED, RED};
        if (phase_q != ALL_RED) heads[active_q] = (phase_q == YELLOW_PH) ? YELLOW : GREEN;
        north_dir_o  = heads[0];
        south_dir_o  = heads[1];
        east_dir_o   = heads[2];
        west_dir_o   = heads[3];
        active_dir_o = active_q;
        phase_o      = phase_q;
        emerg_ack_o  = (phase_q == EMERG_PH);
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed vector table, corner sequences and
// randomized traffic compared against a tick-countdown reference model.
module tb_traffic_phase_scheduler;

    localparam int G = 10;
    localparam int Y = 4;
    localparam int A = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req = 4'd0;
    logic       ev = 1'b0;
    logic [1:0] ed = 2'd0;
    logic [2:0] north, south, east, west;
    logic [1:0] act, ph;
    logic       ack;

    int checks = 0;
    int errors = 0;

    traffic_phase_scheduler #(.GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(A)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .tick_i        (tick),
        .req_i         (req),
        .emerg_valid_i (ev),
        .emerg_dir_i   (ed),
        .north_dir_o   (north),
        .south_dir_o   (south),
        .east_dir_o    (east),
        .west_dir_o    (west),
        .active_dir_o  (act),
        .phase_o       (ph),
        .emerg_ack_o   (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       n;
        bit       tk;
        bit [3:0] rq;
        bit       ev;
        bit [1:0] ed;
        int       ph;
        int       ad;
        bit       ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, bit tk, bit [3:0] rq, bit e, bit [1:0] d,
                                int p, int a, bit k);
        vec_t v;
        v.n = n; v.tk = tk; v.rq = rq; v.ev = e; v.ed = d; v.ph = p; v.ad = a; v.ack = k;
        return v;
    endfunction

    // Reference model: phase, direction, ticks remaining, demand set.
    int       m_ph = 0;
    int       m_dir = 3;
    int       m_left = A;
    bit [3:0] m_pend = 4'd0;

    function automatic int rr_next(bit [3:0] pend, int last);
        for (int k = 1; k <= 4; k++) if (pend[(last + k) % 4]) return (last + k) % 4;
        return (last + 1) % 4;
    endfunction

    function automatic logic [11:0] heads_of(int p, int d);
        logic [11:0] h;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] c;
            c = 3'b100;
            if (p != 0 && i == d) c = (p == 2) ? 3'b010 : 3'b001;
            h[i*3 +: 3] = c;
        end
        return h;
    endfunction

    task automatic model_update();
        bit [3:0] np;
        bit       enter;
        if (reset) begin
            m_ph = 0; m_dir = 3; m_left = A; m_pend = 4'd0;
            return;
        end
        np = m_pend | req;
        enter = 0;
        if (tick) begin
            case (m_ph)
                0: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (ev) begin m_ph = 3; m_dir = int'(ed); end
                        else begin m_dir = rr_next(m_pend, m_dir); m_ph = 1; m_left = G; end
                        enter = 1;
                    end
                end
                1: begin
                    if (ev && int'(ed) == m_dir) begin m_ph = 3; enter = 1; end
                    else if (ev) begin m_ph = 2; m_left = Y; end
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = 2; m_left = Y; end
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = 0; m_left = A; end
                end
                default: if (!ev || int'(ed) != m_dir) begin m_ph = 2; m_left = Y; end
            endcase
        end
        if (enter) np[m_dir] = 1'b0;
        m_pend = np;
    endtask

    task automatic chk(string name, int actual, int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic chk_state(string tag, int p, int d, bit k);
        chk({tag, ".phase"}, int'(ph), p);
        chk({tag, ".active"}, int'(act), d);
        chk({tag, ".ack"}, int'(ack), int'(k));
        chk({tag, ".heads"}, int'({west, east, south, north}), int'(heads_of(p, d)));
    endtask

    task automatic step(bit vs_model);
        model_update();
        @(posedge clk);
        #1;
        if (vs_model) chk_state("model", m_ph, m_dir, (m_ph == 3));
    endtask

    // Safety invariant: every head one-hot, at most one head not red.
    always @(negedge clk) begin
        int nr;
        nr = (north != 3'b100) + (south != 3'b100) + (east != 3'b100) + (west != 3'b100);
        checks++;
        if (!($onehot(north) && $onehot(south) && $onehot(east) && $onehot(west)) || nr > 1) begin
            errors++;
            $display("FAIL heads_safety actual=%b_%b_%b_%b required=onehot,<=1 non-red",
                     north, south, east, west);
        end
    end

    initial begin
        // Directed table, tick every clk unless noted; expectations after n clocks.
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 1, 0, 0)); // N green first
        tbl.push_back(mk( 9, 1, 4'h0, 0, 2'd0, 1, 0, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 2, 0, 0)); // green lasted 10
        tbl.push_back(mk( 4, 1, 4'h0, 0, 2'd0, 0, 0, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 1, 1, 0)); // S next
        tbl.push_back(mk( 1, 1, 4'h8, 0, 2'd0, 1, 1, 0)); // W pulse
        tbl.push_back(mk( 8, 1, 4'h0, 0, 2'd0, 1, 1, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 2, 1, 0));
        tbl.push_back(mk( 4, 1, 4'h0, 0, 2'd0, 0, 1, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 1, 3, 0)); // E skipped
        tbl.push_back(mk( 3, 1, 4'h0, 0, 2'd0, 1, 3, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd2, 2, 3, 0)); // green truncated
        tbl.push_back(mk( 3, 1, 4'h0, 1, 2'd2, 2, 3, 0)); // full yellow
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd2, 0, 3, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd2, 3, 2, 1)); // preempt E
        tbl.push_back(mk(20, 1, 4'h0, 1, 2'd2, 3, 2, 1)); // no timeout
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 2, 2, 0)); // release
        tbl.push_back(mk( 4, 1, 4'h0, 0, 2'd0, 0, 2, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 1, 3, 0)); // resume after E
        tbl.push_back(mk( 2, 0, 4'h0, 1, 2'd3, 1, 3, 0)); // no tick, no effect
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd3, 3, 3, 1)); // same dir: no yellow
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd0, 2, 3, 0)); // dir change
        tbl.push_back(mk( 4, 1, 4'h0, 1, 2'd0, 0, 3, 0));
        tbl.push_back(mk( 1, 1, 4'h0, 1, 2'd0, 3, 0, 1));
        tbl.push_back(mk( 1, 1, 4'h0, 0, 2'd0, 2, 0, 0));
        tbl.push_back(mk( 3, 0, 4'h0, 0, 2'd0, 2, 0, 0));

        reset = 1'b1;
        step(0);
        step(0);
        reset = 1'b0;
        chk_state("reset", 0, 3, 0);

        foreach (tbl[i]) begin
            tick = tbl[i].tk; req = tbl[i].rq; ev = tbl[i].ev; ed = tbl[i].ed;
            for (int c = 0; c < tbl[i].n; c++) begin
                step(1);
                req = 4'd0;
            end
            chk_state($sformatf("vec%0d", i), tbl[i].ph, tbl[i].ad, tbl[i].ack);
        end

        // Reset in the middle of a yellow aborts straight to all-red, rotation restarts at N.
        tick = 1'b1; reset = 1'b1;
        step(1);
        chk_state("midreset", 0, 3, 0);
        reset = 1'b0;
        step(1);
        chk_state("restartN", 1, 0, 0);

        // Only W demand: W serves itself through the full cycle.
        reset = 1'b1; step(1);
        reset = 1'b0; tick = 1'b0; req = 4'h8;
        step(1); step(1);
        tick = 1'b1;
        step(1);
        chk_state("selfW.g1", 1, 3, 0);
        repeat (G) step(1);
        chk_state("selfW.y", 2, 3, 0);
        repeat (Y) step(1);
        chk_state("selfW.ar", 0, 3, 0);
        step(1);
        chk_state("selfW.g2", 1, 3, 0);
        req = 4'd0;

        // Randomized traffic against the model.
        reset = 1'b1; step(1); reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick = ($urandom_range(0, 2) != 0);
            req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 40) == 0) ev = ~ev;
            if ($urandom_range(0, 30) == 0) ed = 2'($urandom);
            reset = ($urandom_range(0, 700) == 0);
            step(1);
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-actuated, round-robin phase scheduler for the four-way intersection signal heads (north/south/east/west).
- Latches per-direction vehicle requests and serves only directions with demand.
- Inserts yellow and all-red clearance between greens.
- Supports emergency-vehicle preemption to any direction.
- Runs on the system clock, qualified by a 1-second tick strobe from the frequency divider.

Parameters:
GREEN_T, 10, green duration in ticks (1..255)
YELLOW_T, 4, yellow duration in ticks (1..255)
ALLRED_T, 1, all-red clearance in ticks (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-clk-wide 1 s enable strobe; all timing advances only on tick
req  in  4  vehicle detect, bit0=N, bit1=S, bit2=E, bit3=W; level, sampled every clk
emerg_valid  in  1  emergency preemption request, sampled on tick
emerg_dir  in  2  preempt direction, 0=N 1=S 2=E 3=W
north_dir  out  3  light code: green=001, yellow=010, red=100
south_dir  out  3  light code
east_dir  out  3  light code
west_dir  out  3  light code
active_dir  out  2  direction currently green/yellow, or last served
phase  out  2  0=ALL_RED 1=GREEN 2=YELLOW 3=EMERG
emerg_ack  out  1  high while in EMERG

Behaviour:
- Reset:
  - All four heads = 100. phase = ALL_RED, count = 0, active_dir = 3 (so north is served first).
  - pending = 0, emerg_ack = 0.
  - A reset mid-phase aborts immediately to this state on the next clk.
- Outputs are registered.
  - At most one head is non-red at any time.
  - The non-red head is always active_dir.
- pending[3:0] demand latch:
  - pending |= req every clk.
  - The bit for direction d clears on the clk entering GREEN or EMERG for d. A same-cycle req for d is dropped.
- Next-direction pick, evaluated at ALL_RED exit:
  - First set pending bit scanning active_dir+1, +2, +3, +0 (mod 4).
  - If pending == 0, pick active_dir+1 (fixed-time recall).
  - active_dir itself can be picked only when no other bit is pending.
- count: 8 bits, increments on tick, clears on every phase change. A phase of length T ends on the tick where count == T-1.
- ALL_RED, end of ALLRED_T:
  - If emerg_valid, go to EMERG with active_dir = emerg_dir.
  - Otherwise go to GREEN with the picked direction.
- GREEN, on each tick:
  - If emerg_valid and emerg_dir == active_dir, go to EMERG (count cleared).
  - Else if emerg_valid, go to YELLOW immediately (green truncated).
  - Else at end of GREEN_T, go to YELLOW.
- YELLOW:
  - Always runs the full YELLOW_T; emergency does not shorten it.
  - Then goes to ALL_RED.
- EMERG:
  - active_dir head is green; emerg_ack = 1; no timeout.
  - On a tick with emerg_valid = 0, or with emerg_dir != active_dir, go to YELLOW.
  - A changed emerg_dir is then served through YELLOW, ALL_RED, EMERG.
- Simultaneous events:
  - emerg_valid is evaluated before normal expiry.
  - Events occurring with tick = 0 take effect only at the next tick, except the pending latch.
- Heads, phase and active_dir update on the same clk as the state change (registered, 1-clk latency from the deciding tick).

Decomposition:
- Package traffic_pkg:
  - Light constants GREEN, YELLOW, RED.
  - dir_t enum {NORTH, SOUTH, EAST, WEST}.
  - phase_t enum {ALL_RED, GREEN_PH, YELLOW_PH, EMERG_PH}.
- Sub-module traffic_rr_pick (combinational):
  - Inputs pending and last dir; outputs next dir.
  - Reused by future pedestrian-phase logic.

Test Plan (defaults, tick every clk):
- Reset, req = 0: ALLRED 1 tick, then N green 10, N yellow 4, ALLRED 1, then S green. Strict N,S,E,W rotation, 15 ticks per direction.
- Pulse req = 4'b0100 (E) while N green, no other demand: after N yellow and ALLRED, E goes green. S is skipped; pending[2] clears on entry.
- Only W demand held, starting from W green: W green, yellow, ALLRED, W green again. Self-service happens only when no other request exists.
- emerg_valid = 1, emerg_dir = 2 at N green count 3:
  - Next tick N = 010 for 4 ticks, then ALLRED 1, then E green with emerg_ack = 1.
  - On drop: E yellow 4, ALLRED, then normal pick resumes from E.
- emerg_valid with emerg_dir = active_dir during green: enters EMERG with no yellow. The head stays 001 indefinitely until release.
- Assert reset during E yellow: next clk all heads 100, phase 0, emerg_ack 0. Rotation restarts at N.
- Every cycle, assertion: at most one head != 100, and the light codes are one-hot.
